// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in, serial-out shift transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit per
// enabled cycle, MSB-first or LSB-first, with a one-cycle done pulse per frame.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit.
module piso_shift_tx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
  localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = WIDTH;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dir;
  logic             done_q;
  logic             accept;
  logic             last_bit;
  logic             data_bit;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  // Handshake and frame-end qualifiers shared by the FSM and datapath.
  assign accept   = load_valid && load_ready;
  assign last_bit = (state == SHIFT) && (cnt == CW'(1)) && shift_en;
  assign data_bit = dir ? sreg[WIDTH-1] : sreg[0];
  assign done     = done_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a reload on the last-bit cycle keeps the FSM in SHIFT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_nxt = accept ? SHIFT : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state; load_ready opens early on the last bit.
  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    sout_valid = 1'b0;
    sout       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
      end
      SHIFT: begin
        busy       = 1'b1;
        sout_valid = 1'b1;
        load_ready = (cnt == CW'(1)) && shift_en;
`ifdef PISO_PARITY_EN
        sout       = (cnt == CW'(1)) ? par : data_bit;
`else
        sout       = data_bit;
`endif
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Datapath: capture on accept, otherwise shift and count down while enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg   <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      done_q <= 1'b0;
`ifdef PISO_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      done_q <= last_bit;
      if (accept) begin
        sreg <= din;
        dir  <= msb_first;
        cnt  <= CW'(FRAME_BITS);
`ifdef PISO_PARITY_EN
        par  <= ^din;
`endif
      end else if ((state == SHIFT) && shift_en && (cnt != '0)) begin
        if (dir) begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
        end else begin
          sreg <= {1'b0, sreg[WIDTH-1:1]};
        end
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (WIDTH=4), both with and without PISO_PARITY_EN.
module tb_piso_shift_tx;

  localparam int unsigned WIDTH = 4;

`ifdef PISO_PARITY_EN
  localparam int          NB        = 5;
  localparam logic [15:0] A_MSB     = 16'b10111;    // 1011 msb-first, parity 1
  localparam logic [15:0] A_LSB     = 16'b11011;    // 1011 lsb-first, parity 1
  localparam logic [15:0] B_MSB     = 16'b01100;    // 0110 msb-first, parity 0
  localparam logic [15:0] STALL_BIT = 16'b0111100;
  localparam logic [15:0] STALL_EN  = 16'b1100111;
  localparam logic [15:0] STALL_LV  = 16'b0011000;
`else
  localparam int          NB        = 4;
  localparam logic [15:0] A_MSB     = 16'b1011;
  localparam logic [15:0] A_LSB     = 16'b1101;
  localparam logic [15:0] B_MSB     = 16'b0110;
  localparam logic [15:0] STALL_BIT = 16'b011110;
  localparam logic [15:0] STALL_EN  = 16'b110011;
  localparam logic [15:0] STALL_LV  = 16'b001100;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [WIDTH-1:0] din = '0;
  logic             msb_first = 1'b0;
  logic             shift_en = 1'b0;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  piso_shift_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .din       (din),
    .msb_first (msb_first),
    .shift_en  (shift_en),
    .sout      (sout),
    .sout_valid(sout_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_sout"},  32'(sout),       32'(0));
    chk({tag, "_valid"}, 32'(sout_valid), 32'(0));
    chk({tag, "_busy"},  32'(busy),       32'(0));
    chk({tag, "_done"},  32'(done),       32'(0));
    chk({tag, "_ready"}, 32'(load_ready), 32'(1));
  endtask

  // One-cycle load pulse; returns in the first-bit cycle.
  task automatic send(input logic [WIDTH-1:0] d, input logic m);
    din        = d;
    msb_first  = m;
    shift_en   = 1'b1;
    load_valid = 1'b1;
    #1;
    chk("send_ready", 32'(load_ready), 32'(1));
    tick();
    load_valid = 1'b0;
  endtask

  // Walks n frame cycles, MSB of each pattern first; done is checked from cycle 1.
  task automatic run_stream(input string tag, input logic [15:0] bits,
                            input logic [15:0] en, input logic [15:0] lv, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k          = n - 1 - i;
      shift_en   = en[k];
      load_valid = lv[k];
      #1;
      chk({tag, "_sout"},  32'(sout),       32'(bits[k]));
      chk({tag, "_valid"}, 32'(sout_valid), 32'(1));
      chk({tag, "_busy"},  32'(busy),       32'(1));
      chk({tag, "_ready"}, 32'(load_ready), 32'((i == n - 1) && en[k]));
      if (i > 0) chk({tag, "_nodone"}, 32'(done), 32'(0));
      tick();
    end
    shift_en   = 1'b1;
    load_valid = 1'b0;
  endtask

  // Cycle after the last bit: done pulse, idle, then done drops.
  task automatic check_end(input string tag);
    #1;
    chk({tag, "_done"},     32'(done),       32'(1));
    chk({tag, "_busy_off"}, 32'(busy),       32'(0));
    chk({tag, "_vld_off"},  32'(sout_valid), 32'(0));
    tick();
    chk({tag, "_done_off"}, 32'(done),       32'(0));
  endtask

  initial begin
    // Reset held for three cycles, then released.
    rst = 1'b0;
    repeat (3) tick();
    check_idle("rst_hold");
    rst = 1'b1;
    tick();
    check_idle("rst_rel");

    // 1011 msb-first.
    send(4'b1011, 1'b1);
    run_stream("msb", A_MSB, 16'hFFFF, 16'h0000, NB);
    check_end("msb_end");

    // 1011 lsb-first; msb_first flipped mid-frame must not matter.
    send(4'b1011, 1'b0);
    msb_first = 1'b1;
    run_stream("lsb", A_LSB, 16'hFFFF, 16'h0000, NB);
    check_end("lsb_end");

    // 0110 msb-first with a two-cycle stall; a load offered during the stall is ignored.
    send(4'b0110, 1'b1);
    din = 4'b1111;
    run_stream("stall", STALL_BIT, STALL_EN, STALL_LV, NB + 2);
    check_end("stall_end");

    // Back-to-back: second word held valid until it is taken on the last-bit cycle.
    send(4'b1011, 1'b1);
    din = 4'b0110;
    run_stream("b2b_a", A_MSB, 16'hFFFF, 16'hFFFF, NB);
    load_valid = 1'b0;
    #1;
    chk("b2b_mid_done",  32'(done),       32'(1));
    chk("b2b_mid_valid", 32'(sout_valid), 32'(1));
    chk("b2b_mid_busy",  32'(busy),       32'(1));
    run_stream("b2b_b", B_MSB, 16'hFFFF, 16'h0000, NB);
    check_end("b2b_end");

    // Asynchronous reset two bits into a frame: clears immediately, no done.
    send(4'b1011, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_idle("async_rst");
    @(posedge clk);
    #1;
    chk("async_rst_nodone", 32'(done), 32'(0));
    rst = 1'b1;
    tick();
    check_idle("post_rst");

    // Fresh frame after release.
    send(4'b1011, 1'b1);
    run_stream("fresh", A_MSB, 16'hFFFF, 16'h0000, NB);
    check_end("fresh_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in, serial-out shift transmitter. It is the transmit-side counterpart of the team's serial-in, parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per enabled cycle, MSB-first or LSB-first.
- Flags the end of each frame.
- Sits between a parallel data source and any serial shift-in consumer.

Parameters:
WIDTH, 4, data word width in bits (legal range >= 2).

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
load_valid  input  1  source presents a word on din
load_ready  output  1  block can accept a word this cycle
din  input  WIDTH  parallel word to transmit
msb_first  input  1  1 = shift out MSB first (left shift); 0 = LSB first (right shift); sampled at load only
shift_en  input  1  bit-rate enable; when 0, the frame stalls
sout  output  1  serial data bit
sout_valid  output  1  sout carries a frame bit this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release):
  - sout=0, sout_valid=0, busy=0, done=0, load_ready=1.
  - Shift register, bit counter and latched direction are all cleared; state=IDLE.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, sout_valid=0, sout=0.
  - On load_valid && load_ready, at the clock edge: sreg<=din, dir<=msb_first, cnt<=WIDTH, state<=SHIFT.
- SHIFT:
  - busy=1, sout_valid=1.
  - sout = dir ? sreg[WIDTH-1] : sreg[0]. Driven from registered state only.
- Latency: the first bit is on sout in the cycle after load acceptance.
- Each SHIFT cycle with shift_en=1:
  - dir=1: sreg<={sreg[WIDTH-2:0],1'b0}.
  - dir=0: sreg<={1'b0,sreg[WIDTH-1:1]}.
  - cnt<=cnt-1.
- shift_en=0 in SHIFT: sreg, cnt and sout hold, and sout_valid stays 1.
- Last bit (cnt==1 && shift_en=1):
  - Next cycle: done=1 for exactly one cycle, and state<=IDLE.
  - Exception: a new word is accepted in the same cycle (see back-to-back).
- load_ready = IDLE || (SHIFT && cnt==1 && shift_en).
- Back-to-back: a word accepted on the last-bit cycle reloads sreg, dir and cnt, and state stays SHIFT.
  - done still pulses once for the completed frame.
  - sout_valid stays high with no gap.
- load_valid while load_ready=0: ignored; din is not captured.
- Changes to msb_first mid-frame have no effect; only the value at acceptance is used.
- Reset mid-frame: the frame is aborted immediately, all outputs take their reset values, and no done pulse is produced.
- Counter width: $clog2(WIDTH+2) bits; it never wraps below 0.

Optional Feature:
Macro PISO_PARITY_EN.
- Defined:
  - Even parity (XOR of din) is captured at load.
  - cnt is loaded with WIDTH+1.
  - After the WIDTH data bits, one extra enabled cycle drives sout=parity with sout_valid=1.
  - done and the back-to-back window move to the end of the parity bit.
- Undefined: frames are exactly WIDTH bits, and no parity logic is present.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> sout=0, sout_valid=0, busy=0, done=0, load_ready=1. Apply rst=0 mid-cycle -> outputs clear without waiting for clk.
2. din=4'b1011, msb_first=1, shift_en=1, one-cycle load_valid -> sout=1,0,1,1 on the 4 cycles after acceptance. done=1 on the 5th cycle, busy=0 on the 5th cycle.
3. din=4'b1011, msb_first=0 -> sout=1,1,0,1. Toggling msb_first mid-frame does not change the sequence.
4. din=4'b0110, msb_first=1, shift_en=0 for 2 cycles after the 2nd bit -> sout holds 1 during the stall. The frame spans 6 cycles with sequence 0,1,1,1,1,0, and done pulses once.
5. Back-to-back: 4'b1011 then 4'b0110 (msb_first=1), the second word held valid until accepted on the last-bit cycle -> 8 contiguous bits 1,0,1,1,0,1,1,0 with sout_valid=1 throughout. done=1 on the first cycle of the second frame and again after it.
6. Reset after 2 bits of 4'b1011 -> no done pulse and load_ready=1. A fresh load after release transmits correctly. With PISO_PARITY_EN defined, 4'b1011 msb-first -> 1,0,1,1,1.
